wait_sched: RTL and testbench

Hardware wait scheduler for dynamic-scheduling event tests: `NSLOT` waiter slots each park on a sensitivity list of posedges and negedges of watched signals plus named-event triggers. A slot resumes when any listed trigger fires. Resumed slots are handed one at a time to a single consumer over a valid/ready port, under round-robin arbitration. It sits between the stimulus/event fabric and the process sequencer that owns the waiting threads.

---
 rtl/wait_sched_pkg.sv | 17 +
 rtl/wait_sched_slot.sv | 129 ++++++++++++
 rtl/wait_sched.sv | 117 +++++++++++
 tb/tb_wait_sched.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wait_sched_pkg.sv
// Shared types for the wait scheduler: wake causes and per-slot FSM states.
package wait_sched_pkg;

  typedef enum logic [1:0] {
    CauseEdge      = 2'd0,
    CauseEvent     = 2'd1,
    CauseTimeout   = 2'd2,
    CauseImmediate = 2'd3
  } cause_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StReady = 2'd2
  } slot_state_e;

endpackage

// File: rtl/wait_sched_slot.sv
// One waiter slot: sensitivity masks, match logic, IDLE/WAIT/READY FSM.
// Optional per-slot timeout down-counter under WAIT_SCHED_TIMEOUT_EN.
module wait_sched_slot
  import wait_sched_pkg::*;
#(
  parameter int unsigned NSIG = 4,
  parameter int unsigned NEVT = 2
`ifdef WAIT_SCHED_TIMEOUT_EN
  ,
  parameter int unsigned TW   = 8
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            arm_i,
  input  logic [NSIG-1:0] pos_i,
  input  logic [NSIG-1:0] neg_i,
  input  logic [NEVT-1:0] evt_i,
`ifdef WAIT_SCHED_TIMEOUT_EN
  input  logic [TW-1:0]   timeout_i,
`endif
  input  logic [NSIG-1:0] rise_i,
  input  logic [NSIG-1:0] fall_i,
  input  logic [NEVT-1:0] evt_trig_i,
  input  logic            release_i,
  output logic            idle_o,
  output logic            ready_o,
  output cause_e          cause_o
);

  slot_state_e     state_q, state_d;
  cause_e          cause_q, cause_d;
  logic [NSIG-1:0] pos_q, neg_q;
  logic [NEVT-1:0] evt_q;
  logic            edge_hit, evt_hit, tmo_hit, arm_tmo_zero, arm_imm;

  assign edge_hit = |(pos_q & rise_i) | |(neg_q & fall_i);
  assign evt_hit  = |(evt_q & evt_trig_i);

`ifdef WAIT_SCHED_TIMEOUT_EN
  logic [TW-1:0] tmr_q, tmr_d;

  // Zero means "no timeout", so only a count of one expires on this edge.
  assign tmo_hit      = (tmr_q == TW'(1));
  assign arm_tmo_zero = (timeout_i == '0);

  always_comb begin
    tmr_d = tmr_q;
    if (state_q == StIdle && arm_i) begin
      tmr_d = timeout_i;
    end else if (state_q == StWait && tmr_q != '0) begin
      tmr_d = tmr_q - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) tmr_q <= '0;
    else        tmr_q <= tmr_d;
  end
`else
  assign tmo_hit      = 1'b0;
  assign arm_tmo_zero = 1'b1;
`endif

  assign arm_imm = ~|pos_i & ~|neg_i & ~|evt_i & arm_tmo_zero;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_q <= '0;
      neg_q <= '0;
      evt_q <= '0;
    end else if (arm_i && state_q == StIdle) begin
      pos_q <= pos_i;
      neg_q <= neg_i;
      evt_q <= evt_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cause_q <= CauseEdge;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      StIdle: begin
        if (arm_i) begin
          if (arm_imm) begin
            state_d = StReady;
            cause_d = CauseImmediate;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        // Edge beats event beats timeout when they coincide.
        if (edge_hit) begin
          state_d = StReady;
          cause_d = CauseEdge;
        end else if (evt_hit) begin
          state_d = StReady;
          cause_d = CauseEvent;
        end else if (tmo_hit) begin
          state_d = StReady;
          cause_d = CauseTimeout;
        end
      end
      StReady: begin
        if (release_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    idle_o  = (state_q == StIdle);
    ready_o = (state_q == StReady);
    cause_o = cause_q;
  end

endmodule

// File: rtl/wait_sched.sv
// Wait scheduler top: edge detection, NSLOT waiter slots, round-robin resume arbiter
// with grant lock. Timeout support is enabled by defining WAIT_SCHED_TIMEOUT_EN.
module wait_sched
  import wait_sched_pkg::*;
#(
  parameter int unsigned NSIG  = 4,
  parameter int unsigned NEVT  = 2,
  parameter int unsigned NSLOT = 4,
  parameter int unsigned TW    = 8,
  localparam int unsigned SW   = $clog2(NSLOT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NSIG-1:0]  sig_i,
  input  logic [NEVT-1:0]  evt_trig_i,
  input  logic             arm_valid_i,
  output logic             arm_ready_o,
  input  logic [SW-1:0]    arm_slot_i,
  input  logic [NSIG-1:0]  arm_pos_i,
  input  logic [NSIG-1:0]  arm_neg_i,
  input  logic [NEVT-1:0]  arm_evt_i,
`ifdef WAIT_SCHED_TIMEOUT_EN
  input  logic [TW-1:0]    arm_timeout_i,
`endif
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [SW-1:0]    res_slot_o,
  output logic [1:0]       res_cause_o,
  output logic [NSLOT-1:0] busy_o
);

  if (NSLOT < 2 || (NSLOT & (NSLOT - 1)) != 0 || TW == 0) begin : g_param_check
    $error("wait_sched: NSLOT must be a power of two >= 2 and TW nonzero");
  end

  logic [NSIG-1:0]  sig_q, rise, fall;
  logic [NSLOT-1:0] slot_idle, slot_ready;
  cause_e           slot_cause [NSLOT];
  logic             arm_hs, res_hs, found;
  logic [SW-1:0]    rr_q, lock_slot_q, pick, grant, idx;
  logic             lock_q;

  // Tracks sig_i even in reset so release never sees a stale edge.
  always_ff @(posedge clk) sig_q <= sig_i;

  assign rise = sig_i & ~sig_q;
  assign fall = ~sig_i & sig_q;

  assign arm_ready_o = slot_idle[arm_slot_i];
  assign arm_hs      = arm_valid_i & arm_ready_o;
  assign busy_o      = ~slot_idle;

  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    wait_sched_slot #(
      .NSIG (NSIG),
      .NEVT (NEVT)
`ifdef WAIT_SCHED_TIMEOUT_EN
      ,
      .TW   (TW)
`endif
    ) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .arm_i      (arm_hs && arm_slot_i == SW'(g)),
      .pos_i      (arm_pos_i),
      .neg_i      (arm_neg_i),
      .evt_i      (arm_evt_i),
`ifdef WAIT_SCHED_TIMEOUT_EN
      .timeout_i  (arm_timeout_i),
`endif
      .rise_i     (rise),
      .fall_i     (fall),
      .evt_trig_i (evt_trig_i),
      .release_i  (res_hs && res_slot_o == SW'(g)),
      .idle_o     (slot_idle[g]),
      .ready_o    (slot_ready[g]),
      .cause_o    (slot_cause[g])
    );
  end

  // First READY slot at or after rr, wrapping.
  always_comb begin
    pick  = rr_q;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      idx = rr_q + SW'(i);
      if (!found && slot_ready[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    grant       = lock_q ? lock_slot_q : pick;
    res_valid_o = lock_q | found;
    res_slot_o  = res_valid_o ? grant : '0;
    res_cause_o = res_valid_o ? slot_cause[grant] : CauseEdge;
    res_hs      = res_valid_o & res_ready_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q        <= '0;
      lock_q      <= 1'b0;
      lock_slot_q <= '0;
    end else if (res_hs) begin
      rr_q   <= grant + SW'(1);
      lock_q <= 1'b0;
    end else if (res_valid_o) begin
      lock_q      <= 1'b1;
      lock_slot_q <= grant;
    end
  end

endmodule

// File: tb/tb_wait_sched.sv
// Self-checking bench for wait_sched: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a slot-array reference model.
module tb_wait_sched;

  localparam int NSIG  = 4;
  localparam int NEVT  = 2;
  localparam int NSLOT = 4;
  localparam int SW    = 2;
  localparam int TW    = 8;
`ifdef WAIT_SCHED_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NSIG-1:0]  sig;
  logic [NEVT-1:0]  evt;
  logic             arm_valid, arm_ready;
  logic [SW-1:0]    arm_slot;
  logic [NSIG-1:0]  arm_pos, arm_neg;
  logic [NEVT-1:0]  arm_evt;
  logic [TW-1:0]    arm_timeout;
  logic             res_valid, res_ready;
  logic [SW-1:0]    res_slot;
  logic [1:0]       res_cause;
  logic [NSLOT-1:0] busy;

  always #5 clk = ~clk;

  wait_sched #(
    .NSIG  (NSIG),
    .NEVT  (NEVT),
    .NSLOT (NSLOT),
    .TW    (TW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sig_i         (sig),
    .evt_trig_i    (evt),
    .arm_valid_i   (arm_valid),
    .arm_ready_o   (arm_ready),
    .arm_slot_i    (arm_slot),
    .arm_pos_i     (arm_pos),
    .arm_neg_i     (arm_neg),
    .arm_evt_i     (arm_evt),
`ifdef WAIT_SCHED_TIMEOUT_EN
    .arm_timeout_i (arm_timeout),
`endif
    .res_valid_o   (res_valid),
    .res_ready_i   (res_ready),
    .res_slot_o    (res_slot),
    .res_cause_o   (res_cause),
    .busy_o        (busy)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state 0 idle, 1 waiting, 2 ready to resume.
  int              m_st    [NSLOT];
  int              m_cause [NSLOT];
  int              m_tmr   [NSLOT];
  logic [NSIG-1:0] m_pos   [NSLOT];
  logic [NSIG-1:0] m_neg   [NSLOT];
  logic [NEVT-1:0] m_evt   [NSLOT];
  int              m_rr    = 0;
  bit              m_lock  = 1'b0;
  int              m_lslot = 0;
  logic [NSIG-1:0] m_prev  = '0;

  initial begin
    for (int s = 0; s < NSLOT; s++) begin
      m_st[s] = 0; m_cause[s] = 0; m_tmr[s] = 0;
      m_pos[s] = '0; m_neg[s] = '0; m_evt[s] = '0;
    end
  end

  // Inputs only change just after posedge, so at negedge they are what the next edge samples.
  always @(negedge clk) begin : compare
    int              pick, g, tmo;
    bit              found, v;
    logic [NSIG-1:0] pe, ne;
    logic [NSLOT-1:0] bexp;
    found = 1'b0;
    pick  = 0;
    for (int i = 0; i < NSLOT; i++) begin
      int k;
      k = (m_rr + i) % NSLOT;
      if (!found && m_st[k] == 2) begin
        pick  = k;
        found = 1'b1;
      end
    end
    v = m_lock || found;
    g = m_lock ? m_lslot : pick;
    for (int s = 0; s < NSLOT; s++) bexp[s] = (m_st[s] != 0);
    if (chk_en) begin
      check("res_valid", res_valid, v);
      check("res_slot", res_slot, v ? g : 0);
      check("res_cause", res_cause, v ? m_cause[g] : 0);
      check("arm_ready", arm_ready, m_st[arm_slot] == 0);
      check("busy", busy, bexp);
    end
    if (!rst_n) begin
      for (int s = 0; s < NSLOT; s++) begin
        m_st[s] = 0; m_cause[s] = 0; m_tmr[s] = 0;
      end
      m_rr = 0; m_lock = 1'b0; m_lslot = 0;
    end else begin
      pe = sig & ~m_prev;
      ne = ~sig & m_prev;
      for (int s = 0; s < NSLOT; s++) begin
        if (m_st[s] == 1) begin
          if (|(m_pos[s] & pe) || |(m_neg[s] & ne)) begin
            m_st[s] = 2; m_cause[s] = 0;
          end else if (|(m_evt[s] & evt)) begin
            m_st[s] = 2; m_cause[s] = 1;
          end else if (m_tmr[s] == 1) begin
            m_st[s] = 2; m_cause[s] = 2;
          end else if (m_tmr[s] > 0) begin
            m_tmr[s]--;
          end
        end
      end
      if (arm_valid && m_st[arm_slot] == 0) begin
        tmo = TmoEn ? int'(arm_timeout) : 0;
        m_pos[arm_slot] = arm_pos;
        m_neg[arm_slot] = arm_neg;
        m_evt[arm_slot] = arm_evt;
        m_tmr[arm_slot] = tmo;
        if (arm_pos == 0 && arm_neg == 0 && arm_evt == 0 && tmo == 0) begin
          m_st[arm_slot] = 2; m_cause[arm_slot] = 3;
        end else begin
          m_st[arm_slot] = 1;
        end
      end
      if (v && res_ready) begin
        m_st[g] = 0;
        m_rr    = (g + 1) % NSLOT;
        m_lock  = 1'b0;
      end else if (v) begin
        m_lock  = 1'b1;
        m_lslot = g;
      end
    end
    m_prev = sig;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, res_valid, 0);
    check({tag, "_slot"}, res_slot, 0);
    check({tag, "_cause"}, res_cause, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_arm_ready"}, arm_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; sig = '0; evt = '0; arm_valid = 1'b0; arm_slot = '0;
    arm_pos = '0; arm_neg = '0; arm_evt = '0; arm_timeout = '0; res_ready = 1'b0;
    repeat (3) step();
    chk_en = 1'b1;
    at_neg();
    check_reset_outputs("rst");
    step(); rst_n = 1'b1;
    step();

    // Posedge wake on sig[0], one cycle after the sampling edge.
    arm_valid = 1'b1; arm_slot = 0; arm_pos = 4'b0001;
    step(); arm_valid = 1'b0; arm_pos = '0;
    sig = 4'b0001;
    step();
    at_neg();
    check("t1_valid", res_valid, 1);
    check("t1_slot", res_slot, 0);
    check("t1_cause", res_cause, 0);
    step(); res_ready = 1'b1;
    step(); res_ready = 1'b0;

    // Two event waiters resumed in round-robin order; grant holds under backpressure.
    arm_valid = 1'b1; arm_slot = 1; arm_evt = 2'b01;
    step(); arm_slot = 2;
    step(); arm_valid = 1'b0; arm_evt = '0;
    evt = 2'b01;
    step(); evt = '0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check("t2_hold_valid", res_valid, 1);
      check("t2_hold_slot", res_slot, 1);
      step();
    end
    res_ready = 1'b1;
    at_neg();
    check("t2_first_slot", res_slot, 1);
    check("t2_first_cause", res_cause, 1);
    step();
    at_neg();
    check("t2_second_valid", res_valid, 1);
    check("t2_second_slot", res_slot, 2);
    step(); res_ready = 1'b0;
    at_neg();
    check("t2_drained", res_valid, 0);
    step();

    // Negedge waiter ignores unmasked event and posedge, wakes on negedge.
    arm_valid = 1'b1; arm_slot = 3; arm_neg = 4'b0010;
    step(); arm_valid = 1'b0; arm_neg = '0;
    evt = 2'b01; sig = 4'b0011;
    step(); evt = '0;
    step();
    at_neg();
    check("t3_no_wake", res_valid, 0);
    step(); sig = 4'b0001;
    step();
    at_neg();
    check("t3_valid", res_valid, 1);
    check("t3_slot", res_slot, 3);
    check("t3_cause", res_cause, 0);
    step(); res_ready = 1'b1;
    step(); res_ready = 1'b0;

    // Empty sensitivity list resumes immediately.
    arm_valid = 1'b1; arm_slot = 0;
    step(); arm_valid = 1'b0;
    at_neg();
    check("t4_imm_valid", res_valid, 1);
    check("t4_imm_slot", res_slot, 0);
    check("t4_imm_cause", res_cause, 3);
    check("t4_no_rearm", arm_ready, 0);
    step(); res_ready = 1'b1;
    step(); res_ready = 1'b0;

    // Edge in the arm-acceptance cycle is not seen.
    sig = 4'b0101; arm_valid = 1'b1; arm_slot = 1; arm_pos = 4'b0100;
    step(); arm_valid = 1'b0; arm_pos = '0;
    step(); step();
    at_neg();
    check("t4_arm_edge_valid", res_valid, 0);
    check("t4_arm_edge_busy", busy, 4'b0010);
    step();

    // Reset with two waiters and one offered resume, sig held high throughout.
    arm_valid = 1'b1; arm_slot = 2; arm_pos = 4'b1000;
    step(); arm_slot = 0; arm_pos = '0;
    step(); arm_valid = 1'b0;
    at_neg();
    check("t5_pre_valid", res_valid, 1);
    check("t5_pre_busy", busy, 4'b0111);
    step(); sig = 4'hF; rst_n = 1'b0;
    step();
    at_neg();
    check_reset_outputs("t5_rst");
    step(); rst_n = 1'b1;
    arm_valid = 1'b1; arm_slot = 1; arm_pos = 4'hF;
    step(); arm_valid = 1'b0; arm_pos = '0;
    step(); step();
    at_neg();
    check("t5_post_valid", res_valid, 0);
    check("t5_post_busy", busy, 4'b0010);
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1; sig = '0;
    step();

`ifdef WAIT_SCHED_TIMEOUT_EN
    // Timeout of 5 with no triggers.
    arm_valid = 1'b1; arm_slot = 0; arm_timeout = 8'd5;
    step(); arm_valid = 1'b0; arm_timeout = '0;
    for (int i = 1; i <= 5; i++) begin
      at_neg();
      check("t6_pending", res_valid, 0);
      step();
    end
    at_neg();
    check("t6_valid", res_valid, 1);
    check("t6_cause", res_cause, 2);
    step(); res_ready = 1'b1;
    step(); res_ready = 1'b0;

    // Edge on the expiry edge wins over timeout.
    arm_valid = 1'b1; arm_slot = 0; arm_pos = 4'b0001; arm_timeout = 8'd3;
    step(); arm_valid = 1'b0; arm_pos = '0; arm_timeout = '0;
    step(); step();
    sig = 4'b0001;
    step();
    at_neg();
    check("t7_valid", res_valid, 1);
    check("t7_cause", res_cause, 0);
    step(); res_ready = 1'b1;
    step(); res_ready = 1'b0;
`endif

    // Randomized traffic; the compare process checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 249) != 0);
      if ($urandom_range(0, 2) == 0) sig = sig ^ NSIG'(1 << $urandom_range(0, NSIG - 1));
      evt = ($urandom_range(0, 4) == 0) ? NEVT'($urandom_range(1, 3)) : '0;
      arm_valid = ($urandom_range(0, 2) == 0);
      arm_slot  = SW'($urandom_range(0, NSLOT - 1));
      if ($urandom_range(0, 4) == 0) begin
        arm_pos = '0; arm_neg = '0; arm_evt = '0;
      end else begin
        arm_pos = NSIG'($urandom) & NSIG'($urandom);
        arm_neg = NSIG'($urandom) & NSIG'($urandom);
        arm_evt = NEVT'($urandom) & NEVT'($urandom);
      end
      arm_timeout = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(1, 7));
      res_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
